// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder step per clock, LSB first, over WIDTH cycles.
// Handshake: start is taken on a rising edge only in IDLE (busy=0, done=0); start seen in RUN or DONE is dropped, never queued.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic [1:0]       o_dbg_state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             w_s;
  logic             w_cout;
  logic             w_last;

  assign w_s    = r_a[0] ^ r_b[0] ^ r_c;
  assign w_cout = (r_a[0] & r_b[0]) | (r_c & (r_a[0] ^ r_b[0]));
  assign w_last = (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy        = (r_state == RUN);
    done        = (r_state == DONE);
    o_dbg_state = r_state;
  end

  // Operands shift right so bit 0 is always the bit being added; sum fills from the MSB side.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_c     <= cin;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
          end
        end
        RUN: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_c   <= w_cout;
          r_sum <= {w_s, r_sum[WIDTH-1:1]};
          if (w_last) begin
            r_carry <= w_cout;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign sum   = r_sum;
  assign carry = r_carry;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit instance for the main scenarios and a 4-bit one swept over all inputs.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start8, cin8, busy8, done8, carry8;
  logic [7:0] a8, b8, sum8;
  logic [1:0] st8;
  logic       start4, cin4, busy4, done4, carry4;
  logic [3:0] a4, b4, sum4;
  logic [1:0] st4;

  int n_checks = 0;
  int n_bad    = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .carry(carry8), .o_dbg_state(st8)
  );

  serial_adder #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .carry(carry4), .o_dbg_state(st4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Presents operands for one edge; returns at the first negedge after acceptance.
  task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic ci);
    @(negedge clk);
    start8 = 1'b1; a8 = a; b8 = b; cin8 = ci;
    @(negedge clk);
    start8 = 1'b0;
  endtask

  // Called in the first cycle after acceptance; checks latency, busy length, result and quiet hold.
  task automatic finish8(input logic [8:0] exp, input string tag, input bit noisy);
    int cyc, busy_n, extra_done;
    logic [8:0] res;
    cyc = 1; busy_n = 0; extra_done = 0;
    while (!done8 && cyc <= 20) begin
      if (busy8) busy_n++;
      if (noisy) begin
        start8 = cyc[0];
        a8 = 8'($urandom_range(0, 255));
        b8 = 8'($urandom_range(0, 255));
        cin8 = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      cyc++;
    end
    start8 = 1'b0;
    check({tag, "_latency"}, cyc, 9);
    check({tag, "_busy_cycles"}, busy_n, 8);
    check({tag, "_busy_in_done"}, busy8, 1'b0);
    res = {carry8, sum8};
    check({tag, "_result"}, res, exp);
    repeat (10) begin
      @(negedge clk);
      if (done8) extra_done++;
    end
    check({tag, "_extra_done"}, extra_done, 0);
    check({tag, "_hold"}, {carry8, sum8}, exp);
  endtask

  initial begin
    int n, cyc, prev, extra_done;
    logic [7:0] bb_a [3];
    logic [7:0] bb_b [3];
    logic       bb_c [3];
    logic [8:0] bb_e [3];
    bb_a = '{8'h01, 8'h80, 8'hAA};
    bb_b = '{8'h02, 8'h80, 8'h55};
    bb_c = '{1'b0, 1'b1, 1'b1};
    bb_e = '{9'h003, 9'h101, 9'h100};

    // Reset with start already high: the first edge after release must accept.
    rst_n = 1'b0;
    start8 = 1'b1; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    start4 = 1'b0; a4 = 4'h0; b4 = 4'h0; cin4 = 1'b0;
    #1;
    check("rst_busy", busy8, 1'b0);
    check("rst_done", done8, 1'b0);
    check("rst_sum", sum8, 8'h00);
    check("rst_carry", carry8, 1'b0);
    check("rst_state", st8, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    check("first_edge_accept", busy8, 1'b1);
    finish8(9'h000, "zero", 1'b0);

    launch8(8'hFF, 8'h01, 1'b0);
    finish8(9'h100, "ff_01", 1'b0);
    launch8(8'hFF, 8'hFF, 1'b1);
    finish8(9'h1FF, "ff_ff_1", 1'b0);
    launch8(8'h5A, 8'h3C, 1'b1);
    finish8(9'h097, "noisy", 1'b1);

    // Abort mid-operation after four bits of 0xFF + 0x00.
    launch8(8'hFF, 8'h00, 1'b0);
    repeat (4) @(negedge clk);
    check("pre_rst_sum", sum8, 8'hF0);
    check("pre_rst_state", st8, 2'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_sum", sum8, 8'h00);
    check("async_rst_carry", carry8, 1'b0);
    check("async_rst_busy", busy8, 1'b0);
    check("async_rst_state", st8, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    extra_done = 0;
    repeat (15) begin
      @(negedge clk);
      if (done8) extra_done++;
    end
    check("post_rst_no_done", extra_done, 0);
    launch8(8'h12, 8'h34, 1'b0);
    finish8(9'h046, "after_rst", 1'b0);

    // start held high: three back-to-back operations.
    @(negedge clk);
    start8 = 1'b1; a8 = bb_a[0]; b8 = bb_b[0]; cin8 = bb_c[0];
    cyc = 0; prev = 0;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      while (!done8 && n < 30) begin
        @(negedge clk);
        cyc++; n++;
      end
      check($sformatf("b2b%0d_result", i), {carry8, sum8}, bb_e[i]);
      if (i > 0) check($sformatf("b2b%0d_spacing", i), cyc - prev, 10);
      prev = cyc;
      if (i < 2) begin
        a8 = bb_a[i+1]; b8 = bb_b[i+1]; cin8 = bb_c[i+1];
      end else begin
        start8 = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end

    // Full sweep of the 4-bit instance against integer addition.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          @(negedge clk);
          start4 = 1'b1; a4 = a[3:0]; b4 = b[3:0]; cin4 = c[0];
          @(negedge clk);
          start4 = 1'b0;
          n = 0;
          while (!done4 && n < 10) begin
            @(negedge clk);
            n++;
          end
          check($sformatf("w4_%0h_%0h_%0d", a, b, c), {carry4, sum4}, a + b + c);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to begin an addition; sampled on rising clk.
REQ-005 a  input  WIDTH  operand A; sampled only when start is accepted.
REQ-006 b  input  WIDTH  operand B; sampled only when start is accepted.
REQ-007 cin  input  1  carry-in; sampled only when start is accepted.
REQ-008 busy  output  1  high while an addition is in progress (state RUN).
REQ-009 done  output  1  single-cycle pulse marking sum/carry valid.
REQ-010 sum  output  WIDTH  result bits, registered.
REQ-011 carry  output  1  carry-out of the MSB, registered.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-013 IDLE: start=1 at a rising edge SHALL be accepted; a, b and cin captured into internal shift registers; sum and carry cleared to 0; bit counter set to 0; next state RUN.
REQ-014 IDLE with start=0 SHALL hold state; sum and carry keep their last values.
REQ-015 RUN: each rising edge SHALL process one bit, LSB first, using the full-adder equations s = a_i ^ b_i ^ c and c' = (a_i & b_i) | (c & (a_i ^ b_i)), where c is the internal carry register.
REQ-016 RUN: s SHALL be written to sum bit i (shift-in from MSB side, or indexed write, result identical); c' SHALL be stored in the carry register; the counter SHALL increment.
REQ-017 After the WIDTH-th RUN edge (counter = WIDTH-1 processed), next state SHALL be DONE and the carry output SHALL equal the final c'.
REQ-018 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-019 Latency: if start is accepted at edge k, done SHALL be high in the cycle following edge k+WIDTH, i.e. WIDTH+1 edges from acceptance to the done pulse.
REQ-020 busy SHALL be 1 only in RUN, and done SHALL be 1 only in DONE; busy and done SHALL never be high simultaneously.
REQ-021 start asserted in RUN or DONE SHALL be ignored (not queued); changes on a, b or cin after acceptance SHALL NOT affect the result.
REQ-022 start held high continuously SHALL produce back-to-back operations: one is accepted in each IDLE cycle, giving a period of WIDTH+2 cycles.
REQ-023 {carry, sum} SHALL equal a + b + cin modulo 2^(WIDTH+1) for all operand values, including all-ones + all-ones + 1.
REQ-024 sum and carry SHALL remain stable from the done cycle until the next start is accepted.
REQ-025 The counter SHALL be sized to at least clog2(WIDTH) bits and SHALL not wrap during an operation.

Reset
REQ-026 rst_n=0 SHALL immediately, without a clock edge, force state IDLE, busy=0, done=0, sum=0, carry=0, and clear the counter, the carry register and the shift registers.
REQ-027 Reset asserted mid-RUN SHALL abort the operation; after release, no done pulse SHALL occur until a new start is accepted.
REQ-028 On the first rising edge after rst_n deasserts, start=1 SHALL be accepted normally.

Verification (WIDTH=8 unless noted)
REQ-029 Reset then start with a=0x00, b=0x00, cin=0 -> done in cycle 9 after acceptance, sum=0x00, carry=0, busy high for exactly 8 cycles.
REQ-030 a=0xFF, b=0x01, cin=0 -> sum=0x00, carry=1; then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, carry=1.
REQ-031 a=0x5A, b=0x3C, cin=1, operands toggled and start pulsed during RUN -> sum=0x97, carry=0, and exactly one done pulse.
REQ-032 rst_n pulsed low in the middle of RUN (counter=4) -> outputs are 0 asynchronously, no done pulse follows, and the next operation (0x12+0x34) gives 0x46.
REQ-033 start held high for 3 operations -> done pulses spaced 10 cycles apart, and each result matches its operands.
REQ-034 Exhaustive run with WIDTH=4 over all a, b, cin (512 cases) -> {carry, sum} == a+b+cin in every case, checked against a reference model.
